keypad_encoder: RTL and testbench
=================================

// Module: keypad_encoder
// PURPOSE
// - Scans a 4x4 matrix keypad, debounces presses and encodes each press into a 4-bit
//   key code with a one-cycle valid strobe.
// - Input-side counterpart of the 7-segment display decoder: it produces the binary
//   digits that the door-lock controller consumes and later displays.
// - Sits between the keypad pins and the lock FSM.
// PARAMETERS
// - SCAN_DIV         1000   clock cycles each column is driven before rows are sampled (>=4)
// - DEBOUNCE_CYCLES  10000  consecutive stable cycles needed to accept a press or a release (>=2)
// PORTS
// - i_clk      in   1  single clock, rising edge
// - i_rst      in   1  synchronous, active-high reset
// - i_en       in   1  scan enable
// - i_row      in   4  keypad rows, active-low (pulled up externally), asynchronous
// - o_col      out  4  keypad column drive, active-low one-hot; 4'b1111 when idle
// - o_binary   out  4  code of the last accepted key
// - o_valid    out  1  one-cycle strobe when o_binary is updated
// - o_pressed  out  1  high while an accepted key is still held
// BEHAVIOUR
// - Reset: o_col=4'b1110 (col0), o_binary=4'h0, o_valid=0, o_pressed=0, state=SCAN,
//   all counters 0.
// - i_row passes through a 2-flop synchronizer; all decisions use the synchronized rows.
// - Key map (row,col) -> code:
//   r0: 1,2,3,A   r1: 4,5,6,B   r2: 7,8,9,C   r3: *=E,0,#=F,D
//   Codes are the hex value; 0-9 map to themselves.
// - SCAN:
//   - Drive the current column for SCAN_DIV cycles. On the last dwell cycle, sample the rows.
//   - Any row low: latch col/row (lowest row index wins if several are low), keep the
//     column driven and go to DEBOUNCE.
//   - Otherwise rotate the column 1110->1101->1011->0111->1110 (wraps).
// - DEBOUNCE:
//   - Count cycles while the latched row stays low.
//   - Row goes high before DEBOUNCE_CYCLES: clear the counter, return to SCAN on the
//     next column, no output.
//   - Count reaches DEBOUNCE_CYCLES: next cycle o_binary<=code, o_valid=1 (1 cycle),
//     o_pressed<=1, go to RELEASE.
// - RELEASE:
//   - Column stays driven. Count consecutive cycles with the latched row high; any low
//     cycle resets the count.
//   - Count reaches DEBOUNCE_CYCLES: o_pressed<=0, go to SCAN on the next column.
//   - No auto-repeat. Other keys are ignored until release.
// - Latency, stable press to o_valid:
//   <= 2 (sync) + SCAN_DIV*4 (worst-case column wait) + DEBOUNCE_CYCLES + 1 cycles.
// - i_en=0 (any state):
//   - Next cycle o_col=4'b1111, o_valid=0, o_pressed=0, counters cleared, state=SCAN,
//     column index=0. o_binary holds its value.
//   - When i_en rises, scanning restarts at col0.
// - i_rst mid-press: reset values apply on the next edge. A key still held is
//   re-detected and reported once more.
// - o_valid never asserts on two consecutive cycles.
// - o_valid and a release can never coincide.
// - Counters are sized $clog2(max(SCAN_DIV,DEBOUNCE_CYCLES)+1) and never wrap.
// STRUCTURE
// - Shared package/include keypad_defs:
//   - key code constants KEY_STAR=4'hE, KEY_HASH=4'hF, KEY_A..KEY_D
//   - state encodings SCAN/DEBOUNCE/RELEASE
//   - column reset pattern COL_IDLE=4'b1111
// - One sub-module: sync_2ff (parameterised width, reset value 1s) for i_row.
// - Everything else, including the FSM, counters and the code lookup, lives in this module.
// TESTING (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
// - Reset then idle rows 4'b1111 -> o_col cycles 1110,1101,1011,0111,1110 every
//   4 clocks; o_valid stays 0.
// - Hold key '5' (row1 low while col1 driven) for 40 cycles:
//   -> exactly one o_valid pulse, o_binary=4'h5, o_pressed=1 until 8 cycles after release.
// - Press '#' with a 3-cycle bounce (row low 3, high 1, then low):
//   -> no valid during the bounce; one pulse with o_binary=4'hF after 8 stable cycles.
// - Rows 1 and 3 low together on col0 -> o_binary=4'h4 (lowest row wins); a single pulse.
// - Drop i_en mid-DEBOUNCE -> o_col=1111 next cycle, no o_valid, o_binary unchanged.
//   Re-raise with the key still held -> scan restarts at col0, then one pulse.
// - Assert i_rst during RELEASE -> all outputs take reset values next cycle.
//   The still-held key is reported again once.

Source files
------------

// File: rtl/keypad_encoder_pkg.sv
// Shared definitions for the keypad encoder: key codes, FSM states, column patterns
// and the (row, col) to key code lookup.
package keypad_encoder_pkg;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam logic [3:0] COL_IDLE  = 4'b1111;
  localparam logic [3:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    StScan     = 2'd0,
    StDebounce = 2'd1,
    StRelease  = 2'd2
  } state_e;

  // Active-low one-hot column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] drv;
    drv = 4'b1111;
    drv[idx] = 1'b0;
    return drv;
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    unique case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = KEY_D;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_encoder_sync_2ff.sv
// Two-flop synchronizer with a synchronous reset to all ones (idle, pulled-up rows).
module sync_2ff #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce and key encoding
// with a one-cycle valid strobe per accepted press.
module keypad_encoder
  import keypad_encoder_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic [3:0] o_binary,
  output logic       o_valid,
  output logic       o_pressed
);

  localparam int unsigned CntMax = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);

  logic [3:0] row_sync;

  sync_2ff #(
    .Width(4)
  ) u_row_sync (
    .clk(i_clk),
    .rst(i_rst),
    .d  (i_row),
    .q  (row_sync)
  );

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      row_q, row_d;
  logic [3:0]      col_drv_q, col_drv_d;
  logic [3:0]      binary_q, binary_d;
  logic            valid_q, valid_d;
  logic            pressed_q, pressed_d;

  logic       any_low;
  logic [1:0] low_idx;
  logic       held;

  // Lowest row index wins when several rows are low.
  always_comb begin
    low_idx = 2'd3;
    if (!row_sync[0])      low_idx = 2'd0;
    else if (!row_sync[1]) low_idx = 2'd1;
    else if (!row_sync[2]) low_idx = 2'd2;
  end

  assign any_low = ~&row_sync;
  assign held    = ~row_sync[row_q];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    binary_d  = binary_q;
    valid_d   = 1'b0;
    pressed_d = pressed_q;

    if (!i_en) begin
      state_d   = StScan;
      cnt_d     = '0;
      col_d     = 2'd0;
      pressed_d = 1'b0;
    end else begin
      unique case (state_q)
        StScan: begin
          if (cnt_q == ScanLast) begin
            cnt_d = '0;
            if (any_low) begin
              row_d   = low_idx;
              state_d = StDebounce;
            end else begin
              col_d = col_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDebounce: begin
          if (held) begin
            if (cnt_q == DebLast) begin
              cnt_d     = '0;
              binary_d  = key_code(row_q, col_q);
              valid_d   = 1'b1;
              pressed_d = 1'b1;
              state_d   = StRelease;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end else begin
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = StScan;
          end
        end
        StRelease: begin
          if (!held) begin
            if (cnt_q == DebLast) begin
              cnt_d     = '0;
              pressed_d = 1'b0;
              col_d     = col_q + 2'd1;
              state_d   = StScan;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = StScan;
          cnt_d   = '0;
        end
      endcase
    end

    col_drv_d = i_en ? col_drive(col_d) : COL_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StScan;
      cnt_q     <= '0;
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      col_drv_q <= COL_RESET;
      binary_q  <= 4'h0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      col_drv_q <= col_drv_d;
      binary_q  <= binary_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
    end
  end

  assign o_col     = col_drv_q;
  assign o_binary  = binary_q;
  assign o_valid   = valid_q;
  assign o_pressed = pressed_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with a behavioural 4x4 keypad driving the rows.
module tb_keypad_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] binary;
  logic       valid;
  logic       pressed;

  logic [15:0] keys;  // bit r*4+c set while key (r,c) is held
  logic [3:0]  last_bin;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[9];
  logic [3:0] col_seq[4];

  always #5 clk = ~clk;

  keypad_encoder #(
    .SCAN_DIV       (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_row    (row),
    .o_col    (col),
    .o_binary (binary),
    .o_valid  (valid),
    .o_pressed(pressed)
  );

  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_pulse(input logic [3:0] exp, input int budget, input string tag);
    int pulses;
    logic [3:0] bin;
    logic pr;
    pulses = 0;
    bin = 4'h0;
    pr = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (valid) begin
        if (pulses == 0) begin
          bin = binary;
          pr  = pressed;
        end
        pulses++;
      end
    end
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_binary"}, {28'd0, bin}, {28'd0, exp});
    check({tag, "_pressed"}, {31'd0, pr}, 32'd1);
    last_bin = exp;
  endtask

  // Pressed must drop exactly 2 sync + 8 debounce cycles after the keys open.
  task automatic release_keys(input string tag);
    int n;
    int v;
    n = 0;
    v = 0;
    keys = 16'h0000;
    while (pressed && n < 30) begin
      tick();
      n++;
      if (valid) v++;
    end
    check({tag, "_release_cycles"}, n, 10);
    check({tag, "_release_valid"}, v, 0);
  endtask

  task automatic wait_col(input logic [3:0] target);
    int n;
    n = 0;
    while (col == target && n < 50) begin
      tick();
      n++;
    end
    while (col != target && n < 100) begin
      tick();
      n++;
    end
    check("wait_col", {28'd0, col}, {28'd0, target});
  endtask

  initial begin
    int v;
    col_seq[0] = 4'b1110;
    col_seq[1] = 4'b1101;
    col_seq[2] = 4'b1011;
    col_seq[3] = 4'b0111;

    vecs[0] = '{keys: 16'h0020, code: 4'h5};
    vecs[1] = '{keys: 16'h0001, code: 4'h1};
    vecs[2] = '{keys: 16'h4000, code: 4'hF};
    vecs[3] = '{keys: 16'h1000, code: 4'hE};
    vecs[4] = '{keys: 16'h0800, code: 4'hC};
    vecs[5] = '{keys: 16'h2000, code: 4'h0};
    vecs[6] = '{keys: 16'h0008, code: 4'hA};
    vecs[7] = '{keys: 16'h8000, code: 4'hD};
    vecs[8] = '{keys: 16'h1010, code: 4'h4};

    keys = 16'h0000;
    en   = 1'b1;
    rst  = 1'b1;
    last_bin = 4'h0;
    tick();
    tick();
    check("reset_col", {28'd0, col}, 32'b1110);
    check("reset_binary", {28'd0, binary}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_pressed", {31'd0, pressed}, 32'd0);

    // Idle scan: column advances every 4 clocks and wraps.
    rst = 1'b0;
    v = 0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) tick();
      if (valid) v++;
      check($sformatf("idle_col_%0d", k), {28'd0, col}, {28'd0, col_seq[(k/4)%4]});
    end
    check("idle_valid", v, 0);

    for (int i = 0; i < 9; i++) begin
      keys = vecs[i].keys;
      wait_pulse(vecs[i].code, 60, $sformatf("vec%0d", i));
      release_keys($sformatf("vec%0d", i));
    end

    // '#' with a bounce inside debounce: abort moves on to column 3, then a clean press.
    wait_col(4'b1011);
    v = 0;
    keys = 16'h4000;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (valid) v++;
    end
    keys = 16'h0000;
    tick();
    if (valid) v++;
    keys = 16'h4000;
    tick();
    if (valid) v++;
    tick();
    if (valid) v++;
    check("bounce_valid", v, 0);
    check("bounce_abort_col", {28'd0, col}, 32'b0111);
    wait_pulse(4'hF, 60, "bounce");
    release_keys("bounce");

    // Drop enable while debouncing '5'.
    wait_col(4'b1101);
    keys = 16'h0020;
    for (int i = 0; i < 6; i++) tick();
    en = 1'b0;
    tick();
    check("en_off_col", {28'd0, col}, 32'b1111);
    check("en_off_valid", {31'd0, valid}, 32'd0);
    check("en_off_binary", {28'd0, binary}, {28'd0, last_bin});
    check("en_off_pressed", {31'd0, pressed}, 32'd0);
    v = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (valid || col != 4'b1111) v++;
    end
    check("en_off_hold", v, 0);
    en = 1'b1;
    tick();
    check("en_restart_col", {28'd0, col}, 32'b1110);
    wait_pulse(4'h5, 60, "en_restart");
    release_keys("en_restart");

    // Reset while '9' is held in release.
    keys = 16'h0400;
    wait_pulse(4'h9, 60, "pre_rst");
    rst = 1'b1;
    tick();
    check("rst_mid_col", {28'd0, col}, 32'b1110);
    check("rst_mid_binary", {28'd0, binary}, 32'd0);
    check("rst_mid_valid", {31'd0, valid}, 32'd0);
    check("rst_mid_pressed", {31'd0, pressed}, 32'd0);
    rst = 1'b0;
    wait_pulse(4'h9, 60, "post_rst");
    release_keys("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
